sbox_ti_sched: RTL
==================

SBOX_TI_SCHED -- requirements
Module: sbox_ti_sched

Interface
REQ-001 SHALL have parameter SEED, default 32'hA5C3_0F1E, meaning the PRNG reset seed (nonzero).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port d_req, input, 1, data-path S-box request.
REQ-005 SHALL have port d_gnt, output, 1, data request accepted this cycle.
REQ-006 SHALL have port k_req, input, 1, key-schedule S-box request.
REQ-007 SHALL have port k_gnt, output, 1, key request accepted this cycle.
REQ-008 SHALL have port sel_key, output, 1, input mux select for the S-box (1 = key operand); equals k_gnt.
REQ-009 SHALL have port pipe_en, output, 4, register enable for stage registers 0..3 of the masked S-box pipeline.
REQ-010 SHALL have port rnd, output, 24, fresh masks for the Stage3 refresh (r0..r5 = rnd[3:0]..rnd[23:20]).
REQ-011 SHALL have port out_vld, output, 1, S-box result valid at pipeline output.
REQ-012 SHALL have port out_tag, output, 1, owner of the output result (0 data, 1 key).
REQ-013 SHALL have port out_rdy, input, 1, consumer accepts the result.
REQ-014 SHALL have port busy, output, 1, OR of all stage valid bits.

Function
REQ-015 SHALL track a 4-entry valid vector v[3:0] and tag vector t[3:0]; out_vld = v[3], out_tag = t[3].
REQ-016 SHALL define adv = !(v[3] & !out_rdy); when adv = 0 the whole pipeline holds, pipe_en = 4'b0000, no grants.
REQ-017 When adv = 1, v and t SHALL shift one stage per cycle; v[0] is loaded with (d_gnt | k_gnt) and t[0] with k_gnt.
REQ-018 SHALL set pipe_en[0] = adv & (d_gnt | k_gnt) and pipe_en[i] = adv & v[i-1] for i = 1..3.
REQ-019 Latency SHALL be exactly 4 cycles: grant in cycle n, out_vld in cycle n+4 absent stalls; each stall cycle adds one.
REQ-020 At most one grant per cycle; d_gnt and k_gnt SHALL be mutually exclusive.
REQ-021 Arbitration SHALL be round-robin with a 1-bit last-winner pointer: when both request, the requester not granted last wins; a single requester always wins when adv = 1.
REQ-022 The pointer SHALL update only on a grant.
REQ-023 The PRNG SHALL be a 32-bit xorshift (x ^= x<<13; x ^= x>>17; x ^= x<<5); rnd = x[23:0].
REQ-024 The PRNG SHALL step only in cycles where pipe_en[2] = 1, so each token entering Stage3 uses a distinct rnd value.
REQ-025 PRNG state SHALL never be zero.
REQ-026 Back-to-back grants SHALL sustain one result per cycle when out_rdy = 1.

Reset
REQ-027 On RST = 1: v = 0, t = 0, pointer = 0 (data wins first tie), PRNG = SEED; all grant outputs, pipe_en, out_vld, out_tag and busy are 0 in the following cycle.
REQ-028 RST mid-operation SHALL discard all in-flight tokens; RST has priority over every other input.

Configuration
REQ-029 With SBOX_TI_PRNG_RESEED_EN defined, ports seed_ld (in, 1) and seed (in, 32) SHALL exist: seed_ld = 1 loads seed into the PRNG at the next edge, overriding a step; a zero seed loads SEED instead.
REQ-030 Without SBOX_TI_PRNG_RESEED_EN, those ports SHALL be absent and the PRNG is reloaded only by RST.

Verification
REQ-031 Reset, then d_req = 1 for one cycle with out_rdy = 1 -> d_gnt in cycle 1, out_vld = 1 and out_tag = 0 exactly in cycle 5, busy = 0 afterwards.
REQ-032 d_req = k_req = 1 continuously, out_rdy = 1 -> grants alternate d, k, d, k starting with d; out_tag sequence 0,1,0,1 from 4 cycles later.
REQ-033 4 back-to-back grants, then out_rdy = 0 for 3 cycles -> out_vld held, pipe_en = 0, no grants for 3 cycles, no token lost or duplicated.
REQ-034 After reset, first Stage3 capture uses rnd = SEED[23:0] = 24'hC30F1E; the next capture uses xorshift(SEED)[23:0]; rnd is unchanged during stalls.
REQ-035 RST asserted with 3 tokens in flight -> next cycle out_vld = 0, busy = 0, and the next result appears only for new grants.
REQ-036 (RESEED_EN) seed_ld with seed = 0 -> PRNG equals SEED; with seed = 32'h1 -> next Stage3 capture uses rnd = 24'h000001.

Source files
------------

// File: rtl/sbox_ti_sched.sv
// Scheduler for a shared 4-stage masked S-box: round-robin data/key arbitration, stage valid/tag
// tracking, stall handling and an xorshift mask generator. Optional reseed port: SBOX_TI_PRNG_RESEED_EN.
module sbox_ti_sched #(
    parameter logic [31:0] SEED = 32'hA5C3_0F1E
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        d_req,
    output logic        d_gnt,
    input  logic        k_req,
    output logic        k_gnt,
    output logic        sel_key,
    output logic [3:0]  pipe_en,
    output logic [23:0] rnd,
    output logic        out_vld,
    output logic        out_tag,
    input  logic        out_rdy,
    output logic        busy
`ifdef SBOX_TI_PRNG_RESEED_EN
    ,
    input  logic        seed_ld,
    input  logic [31:0] seed
`endif
);

    logic [3:0]  v;
    logic [3:0]  t;
    logic        prio_key;
    logic [31:0] x;
    logic [31:0] x_step;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        adv;
    logic        key_wins;

    // prio_key = 1 means the key requester was not granted last and wins the next tie
    always_comb begin
        adv      = !(v[3] && !out_rdy);
        key_wins = k_req && (!d_req || prio_key);
        d_gnt    = adv && !RST && d_req && !key_wins;
        k_gnt    = adv && !RST && key_wins;
        sel_key  = k_gnt;
        pipe_en  = {adv && v[2], adv && v[1], adv && v[0], adv && (d_gnt || k_gnt)};
        out_vld  = v[3];
        out_tag  = t[3];
        busy     = |v;
        rnd      = x[23:0];
        s1       = x ^ (x << 13);
        s2       = s1 ^ (s1 >> 17);
        x_step   = s2 ^ (s2 << 5);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v        <= 4'b0000;
            t        <= 4'b0000;
            prio_key <= 1'b0;
            x        <= SEED;
        end else begin
            if (adv) begin
                v <= {v[2:0], d_gnt || k_gnt};
                t <= {t[2:0], k_gnt};
            end
            if (d_gnt) begin
                prio_key <= 1'b1;
            end else if (k_gnt) begin
                prio_key <= 1'b0;
            end
            // xorshift is a bijection on nonzero words, so stepping never reaches zero
`ifdef SBOX_TI_PRNG_RESEED_EN
            if (seed_ld) begin
                x <= (seed == 32'h0) ? SEED : seed;
            end else if (pipe_en[2]) begin
                x <= x_step;
            end
`else
            if (pipe_en[2]) begin
                x <= x_step;
            end
`endif
        end
    end

endmodule
